out_mapper: RTL and testbench

- Reverse-direction counterpart of the AER-to-SpiNNaker input mapper.
- Accepts 72-bit SpiNNaker packets from the SpiNNaker link receiver and checks parity and packet type.
- Strips the header and parity from good multicast packets, buffers the 32-bit routing key in a small FIFO, and presents it to the output AER device.
- Protects the SpiNNaker side by dumping events when the AER device stops responding.

---
 rtl/out_mapper.sv | 139 +++++++++++++
 tb/tb_out_mapper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_mapper.sv
// SpiNNaker-to-AER output mapper: checks parity and type on incoming packets, buffers multicast
// routing keys in a small FIFO, and discards events while the AER device is unresponsive.
// Optional error counter is built when OUT_MAPPER_ERR_CNT_EN is defined.
module out_mapper #(
   parameter int FIFO_DEPTH  = 3,
   parameter int DUMP_CYCLES = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        dump_mode,
   output logic        parity_err,
   output logic        type_err,
   output logic [15:0] err_cnt,
   input  logic [71:0] opkt_data,
   input  logic        opkt_vld,
   output logic        opkt_rdy,
   output logic [31:0] oaer_data,
   output logic        oaer_vld,
   input  logic        oaer_rdy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR    = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
   localparam logic [7:0]    DUMP_RELOAD = 8'(DUMP_CYCLES);

   // Odd parity covers the header+key only, or the whole packet when a payload is present.
   function automatic logic parity_ok(input logic [71:0] pkt);
      if (pkt[1]) begin
         return ^pkt;
      end
      return ^pkt[39:0];
   endfunction

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
      if (ptr == LAST_PTR) begin
         return '0;
      end
      return ptr + PW'(1);
   endfunction

   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    dump_cnt;

   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic pkt_par_ok;
   logic pkt_mc;
   logic push;
   logic pop;

   assign fifo_full  = (count == FULL_COUNT);
   assign fifo_empty = (count == '0);

   assign opkt_rdy   = ~fifo_full | dump_mode;
   assign accept     = opkt_vld & opkt_rdy;
   assign pkt_par_ok = parity_ok(opkt_data);
   assign pkt_mc     = (opkt_data[7:6] == 2'b00);
   assign push       = accept & pkt_par_ok & pkt_mc;

   // In dump mode the head is dropped every cycle, so a full FIFO can still take a push.
   assign pop        = ~fifo_empty & (oaer_rdy | dump_mode);

   assign oaer_vld   = ~fifo_empty;
   assign oaer_data  = fifo_empty ? 32'h0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= opkt_data[39:8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Watchdog on the AER device: runs regardless of FIFO occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dump_cnt  <= DUMP_RELOAD;
         dump_mode <= 1'b0;
      end else if (oaer_rdy) begin
         dump_cnt  <= DUMP_RELOAD;
         dump_mode <= 1'b0;
      end else if (dump_cnt != 8'd0) begin
         dump_cnt  <= dump_cnt - 8'd1;
      end else begin
         dump_mode <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
         type_err   <= 1'b0;
      end else begin
         parity_err <= accept & ~pkt_par_ok;
         type_err   <= accept & pkt_par_ok & ~pkt_mc;
      end
   end

`ifdef OUT_MAPPER_ERR_CNT_EN
   logic [15:0] err_total;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_total <= 16'h0000;
      end else if ((parity_err | type_err) && (err_total != 16'hFFFF)) begin
         err_total <= err_total + 16'h0001;
      end
   end

   assign err_cnt = err_total;
`else
   assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_out_mapper.sv
// Directed bench for out_mapper: reset, parity/type filtering, backpressure,
// dump mode and asynchronous reset with buffered events.
module tb_out_mapper;

   localparam int DUMP_CYCLES = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dump_mode;
   logic        parity_err;
   logic        type_err;
   logic [15:0] err_cnt;
   logic [71:0] opkt_data;
   logic        opkt_vld;
   logic        opkt_rdy;
   logic [31:0] oaer_data;
   logic        oaer_vld;
   logic        oaer_rdy;

   int passed = 0;
   int total  = 0;

   out_mapper #(.FIFO_DEPTH(3), .DUMP_CYCLES(DUMP_CYCLES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_mode  (dump_mode),
      .parity_err (parity_err),
      .type_err   (type_err),
      .err_cnt    (err_cnt),
      .opkt_data  (opkt_data),
      .opkt_vld   (opkt_vld),
      .opkt_rdy   (opkt_rdy),
      .oaer_data  (oaer_data),
      .oaer_vld   (oaer_vld),
      .oaer_rdy   (oaer_rdy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      opkt_vld  = 1'b0;
      opkt_data = 72'h0;
      oaer_rdy  = 1'b1;
      step();
      step();
      total++; if (oaer_vld !== 1'b0) $display("FAIL reset_oaer_vld got %b want 0", oaer_vld); else passed++;
      total++; if (oaer_data !== 32'h0) $display("FAIL reset_oaer_data got %h want 0", oaer_data); else passed++;
      total++; if (opkt_rdy !== 1'b1) $display("FAIL reset_opkt_rdy got %b want 1", opkt_rdy); else passed++;
      total++; if ({dump_mode, parity_err, type_err} !== 3'b000)
         $display("FAIL reset_flags got %b want 000", {dump_mode, parity_err, type_err}); else passed++;
      total++; if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt got %h want 0", err_cnt); else passed++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      oaer_rdy  = 1'b1;
      opkt_data = 72'h0000000000_1234567800;
      opkt_vld  = 1'b1;
      total++; if (opkt_rdy !== 1'b1) $display("FAIL single_opkt_rdy got %b want 1", opkt_rdy); else passed++;
      step();
      opkt_vld = 1'b0;
      total++; if (oaer_vld !== 1'b1) $display("FAIL single_vld got %b want 1", oaer_vld); else passed++;
      total++; if (oaer_data !== 32'h12345678) $display("FAIL single_data got %h want 12345678", oaer_data); else passed++;
      step();
      total++; if (oaer_vld !== 1'b0) $display("FAIL single_empty got %b want 0", oaer_vld); else passed++;
   endtask

   task automatic test_parity();
      logic [15:0] exp_cnt;
      opkt_data = 72'h0000000000_1234567801;
      opkt_vld  = 1'b1;
      step();
      opkt_vld = 1'b0;
      total++; if (parity_err !== 1'b1) $display("FAIL par_pulse got %b want 1", parity_err); else passed++;
      total++; if (type_err !== 1'b0) $display("FAIL par_no_type got %b want 0", type_err); else passed++;
      total++; if (oaer_vld !== 1'b0) $display("FAIL par_no_event got %b want 0", oaer_vld); else passed++;
      step();
      total++; if (parity_err !== 1'b0) $display("FAIL par_single_pulse got %b want 0", parity_err); else passed++;
`ifdef OUT_MAPPER_ERR_CNT_EN
      exp_cnt = 16'd1;
`else
      exp_cnt = 16'd0;
`endif
      total++; if (err_cnt !== exp_cnt) $display("FAIL par_err_cnt got %0d want %0d", err_cnt, exp_cnt); else passed++;

      // payload flag set: parity spans all 72 bits (payload 1 + key 13 + flag 1 = odd)
      opkt_data = 72'h00000001_12345678_02;
      opkt_vld  = 1'b1;
      step();
      opkt_vld = 1'b0;
      total++; if (parity_err !== 1'b0) $display("FAIL par72_good_err got %b want 0", parity_err); else passed++;
      total++; if (oaer_data !== 32'h12345678 || oaer_vld !== 1'b1)
         $display("FAIL par72_good_event got %b/%h want 1/12345678", oaer_vld, oaer_data); else passed++;
      step();
      opkt_data = 72'h00000000_12345678_02;
      opkt_vld  = 1'b1;
      step();
      opkt_vld = 1'b0;
      total++; if (parity_err !== 1'b1) $display("FAIL par72_bad_err got %b want 1", parity_err); else passed++;
      total++; if (oaer_vld !== 1'b0) $display("FAIL par72_bad_event got %b want 0", oaer_vld); else passed++;
      step();
   endtask

   task automatic test_type();
      logic [15:0] exp_cnt;
      opkt_data = 72'h0000000000_1234567881;
      opkt_vld  = 1'b1;
      step();
      opkt_vld = 1'b0;
      total++; if (type_err !== 1'b1) $display("FAIL type_pulse got %b want 1", type_err); else passed++;
      total++; if (parity_err !== 1'b0) $display("FAIL type_no_par got %b want 0", parity_err); else passed++;
      total++; if (oaer_vld !== 1'b0) $display("FAIL type_no_event got %b want 0", oaer_vld); else passed++;
      step();
      total++; if (type_err !== 1'b0) $display("FAIL type_single_pulse got %b want 0", type_err); else passed++;
`ifdef OUT_MAPPER_ERR_CNT_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      total++; if (err_cnt !== exp_cnt) $display("FAIL type_err_cnt got %0d want %0d", err_cnt, exp_cnt); else passed++;
   endtask

   task automatic test_backpressure();
      logic [71:0] pkts [4];
      pkts[0] = 72'h0000000000_0000000100;
      pkts[1] = 72'h0000000000_0000000200;
      pkts[2] = 72'h0000000000_0000000301;
      pkts[3] = 72'h0000000000_0000000400;
      oaer_rdy = 1'b0;
      opkt_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         opkt_data = pkts[i];
         total++; if (opkt_rdy !== 1'b1) $display("FAIL bp_rdy_%0d got %b want 1", i, opkt_rdy); else passed++;
         step();
      end
      opkt_data = pkts[3];
      total++; if (opkt_rdy !== 1'b0) $display("FAIL bp_full_rdy got %b want 0", opkt_rdy); else passed++;
      step();
      step();
      total++; if (opkt_rdy !== 1'b0) $display("FAIL bp_stall_rdy got %b want 0", opkt_rdy); else passed++;
      total++; if (oaer_data !== 32'h1) $display("FAIL bp_head got %h want 1", oaer_data); else passed++;
      oaer_rdy = 1'b1;
      #1;
      total++; if (oaer_data !== 32'h1) $display("FAIL bp_out_1 got %h want 1", oaer_data); else passed++;
      step();
      total++; if (oaer_data !== 32'h2) $display("FAIL bp_out_2 got %h want 2", oaer_data); else passed++;
      total++; if (opkt_rdy !== 1'b1) $display("FAIL bp_reopen got %b want 1", opkt_rdy); else passed++;
      step();
      opkt_vld = 1'b0;
      total++; if (oaer_data !== 32'h3) $display("FAIL bp_out_3 got %h want 3", oaer_data); else passed++;
      step();
      total++; if (oaer_data !== 32'h4 || oaer_vld !== 1'b1)
         $display("FAIL bp_out_4 got %b/%h want 1/4", oaer_vld, oaer_data); else passed++;
      step();
      total++; if (oaer_vld !== 1'b0) $display("FAIL bp_drained got %b want 0", oaer_vld); else passed++;
   endtask

   task automatic test_dump();
      logic [71:0] pkts [3];
      bit found;
      pkts[0] = 72'h0000000000_0000000A01;
      pkts[1] = 72'h0000000000_0000000B00;
      pkts[2] = 72'h0000000000_0000000C01;
      oaer_rdy = 1'b0;
      opkt_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         opkt_data = pkts[i];
         step();
      end
      opkt_vld = 1'b0;
      total++; if (dump_mode !== 1'b0 || opkt_rdy !== 1'b0)
         $display("FAIL dump_early got dump=%b rdy=%b want 0/0", dump_mode, opkt_rdy); else passed++;
      found = 1'b0;
      for (int i = 3; i < DUMP_CYCLES + 2; i++) begin
         if (dump_mode === 1'b1) begin
            found = 1'b1;
            break;
         end
         step();
      end
      if (dump_mode === 1'b1) found = 1'b1;
      total++; if (!found) $display("FAIL dump_enter got dump_mode=%b want 1", dump_mode); else passed++;
      total++; if (opkt_rdy !== 1'b1) $display("FAIL dump_rdy got %b want 1", opkt_rdy); else passed++;
      total++; if (oaer_vld !== 1'b1 || oaer_data !== 32'hA)
         $display("FAIL dump_full got %b/%h want 1/a", oaer_vld, oaer_data); else passed++;
      opkt_data = 72'h0000000000_0000000D00;
      opkt_vld  = 1'b1;
      step();
      opkt_vld = 1'b0;
      total++; if (oaer_data !== 32'hB) $display("FAIL dump_pushpop got %h want b", oaer_data); else passed++;
      step();
      step();
      total++; if (oaer_data !== 32'hD || oaer_vld !== 1'b1)
         $display("FAIL dump_tail got %b/%h want 1/d", oaer_vld, oaer_data); else passed++;
      step();
      total++; if (oaer_vld !== 1'b0) $display("FAIL dump_drained got %b want 0", oaer_vld); else passed++;
      oaer_rdy = 1'b1;
      #1;
      total++; if (dump_mode !== 1'b1) $display("FAIL dump_hold got %b want 1", dump_mode); else passed++;
      step();
      total++; if (dump_mode !== 1'b0) $display("FAIL dump_exit got %b want 0", dump_mode); else passed++;
   endtask

   task automatic test_async_reset();
      oaer_rdy  = 1'b0;
      opkt_vld  = 1'b1;
      opkt_data = 72'h0000000000_0000001101;
      step();
      opkt_data = 72'h0000000000_0000002201;
      step();
      opkt_vld = 1'b0;
      total++; if (oaer_vld !== 1'b1 || oaer_data !== 32'h11)
         $display("FAIL ar_buffered got %b/%h want 1/11", oaer_vld, oaer_data); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (oaer_vld !== 1'b0) $display("FAIL ar_immediate got %b want 0", oaer_vld); else passed++;
      total++; if (oaer_data !== 32'h0) $display("FAIL ar_data got %h want 0", oaer_data); else passed++;
      step();
      rst_n    = 1'b1;
      oaer_rdy = 1'b1;
      step();
      step();
      step();
      total++; if (oaer_vld !== 1'b0) $display("FAIL ar_stays_empty got %b want 0", oaer_vld); else passed++;
      opkt_data = 72'h0000000000_0000005501;
      opkt_vld  = 1'b1;
      step();
      opkt_vld = 1'b0;
      total++; if (oaer_vld !== 1'b1 || oaer_data !== 32'h55)
         $display("FAIL ar_new_event got %b/%h want 1/55", oaer_vld, oaer_data); else passed++;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_type();
      test_backpressure();
      test_dump();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
